stream_downsize: RTL and testbench

STREAM_DOWNSIZE -- requirements
Module: stream_downsize

---
 rtl/stream_downsize.sv | 71 +++++++
 tb/tb_stream_downsize.sv | 115 +++++++++++
 2 files changed

// File: rtl/stream_downsize.sv
// stream_downsize: splits a wide keep-qualified beat into narrow words, skipping unkept lanes.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);
    localparam int IW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    logic [0:0]              state_q, state_d;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
    // mask_q holds lanes still to be presented, excluding the word currently on m_data_o
    logic [T_DATA_RATIO-1:0] mask_q, mask_d, src_mask, rest;
    logic                    last_q, last_d, src_last;
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d, src_word;
    logic                    m_last_q, m_last_d, m_valid_q, m_valid_d;
    logic [IW-1:0]           idx;
    logic                    accept, fire, load;
    assign s_ready_o = !rst_n && (state_q == IDLE || (mask_q == '0 && m_ready_i));
    assign accept    = s_valid_i && s_ready_o;
    assign fire      = m_valid_q && m_ready_i;
    assign load      = accept || (fire && mask_q != '0);
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;
    always_comb begin
        src_mask = accept ? s_keep_i : mask_q;
        src_last = accept ? s_last_i : last_q;
        idx = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--)
            if (src_mask[i]) idx = IW'(i);
        src_word  = accept ? s_data_i[idx] : data_q[idx];
        rest      = src_mask & ~(T_DATA_RATIO'(1) << idx);
        mask_d    = load ? rest : mask_q;
        last_d    = accept ? s_last_i : last_q;
        m_valid_d = load ? |src_mask : (fire ? 1'b0 : m_valid_q);
        m_last_d  = load ? (|src_mask && src_last && rest == '0) : (fire ? 1'b0 : m_last_q);
        m_data_d  = (load && |src_mask) ? src_word : m_data_q;
        state_d   = m_valid_d ? SEND : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            last_q    <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            last_q    <= last_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end
    always_ff @(posedge clk)
        if (accept) data_q <= s_data_i;
endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: directed vectors for the 4x8-bit downsizer.
module tb_stream_downsize;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data [3:0];
    logic [3:0] s_keep;
    logic       s_last, s_valid, s_ready;
    logic [7:0] m_data;
    logic       m_last, m_valid, m_ready;
    int total = 0;
    int bad = 0;
    stream_downsize #(.T_DATA_WIDTH(8), .T_DATA_RATIO(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_data_i(s_data), .s_keep_i(s_keep),
        .s_last_i(s_last), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_last_o(m_last), .m_valid_o(m_valid), .m_ready_i(m_ready)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        for (int i = 0; i < 4; i++) s_data[i] = d[8*i +: 8];
        s_keep  = k;
        s_last  = l;
        s_valid = 1'b1;
    endtask
    task automatic word(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_v"}, m_valid, 1);
        chk({tag, "_d"}, m_data, d);
        chk({tag, "_l"}, m_last, l);
    endtask
    initial begin
        rst_n = 1'b1; m_ready = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_keep = 4'h0;
        for (int i = 0; i < 4; i++) s_data[i] = 8'h00;
        step(); step();
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_sready", s_ready, 0);
        rst_n = 1'b0; #1;
        chk("rel_sready", s_ready, 1);
        // full beat, last packet
        beat(32'h44332211, 4'hF, 1'b1);
        step(); s_valid = 1'b0;
        word("full0", 8'h11, 0); chk("full0_sr", s_ready, 0); step();
        word("full1", 8'h22, 0); step();
        word("full2", 8'h33, 0); step();
        word("full3", 8'h44, 1); chk("full3_sr", s_ready, 1); step();
        chk("full_idle_v", m_valid, 0); chk("full_idle_sr", s_ready, 1);
        // sparse keep
        beat(32'hD4C3B2A1, 4'b1010, 1'b0);
        step(); s_valid = 1'b0;
        word("sp0", 8'hB2, 0); chk("sp0_sr", s_ready, 0); step();
        word("sp1", 8'hD4, 0); chk("sp1_sr", s_ready, 1); step();
        chk("sp_idle_v", m_valid, 0);
        // backpressure mid-beat
        beat(32'h54535251, 4'hF, 1'b1);
        step(); s_valid = 1'b0;
        word("bp0", 8'h51, 0); step();
        word("bp1", 8'h52, 0);
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1; chk("bp_hold_sr", s_ready, 0);
            step(); word("bp_hold", 8'h52, 0);
        end
        m_ready = 1'b1; step();
        word("bp2", 8'h53, 0); step();
        word("bp3", 8'h54, 1); step();
        chk("bp_idle_v", m_valid, 0);
        // back-to-back beats with s_valid held
        beat(32'h64636261, 4'hF, 1'b0);
        step();
        beat(32'hEEEEEE71, 4'b0001, 1'b1);
        word("bb0", 8'h61, 0); chk("bb0_sr", s_ready, 0); step();
        word("bb1", 8'h62, 0); chk("bb1_sr", s_ready, 0); step();
        word("bb2", 8'h63, 0); chk("bb2_sr", s_ready, 0); step();
        word("bb3", 8'h64, 0); chk("bb3_sr", s_ready, 1); step();
        s_valid = 1'b0;
        word("bb4", 8'h71, 1); step();
        chk("bb_idle_v", m_valid, 0);
        // empty keep with last
        beat(32'hFFFFFFFF, 4'h0, 1'b1);
        chk("z_sr", s_ready, 1);
        step(); s_valid = 1'b0;
        chk("z_v0", m_valid, 0); chk("z_sr1", s_ready, 1); step();
        chk("z_v1", m_valid, 0); chk("z_l1", m_last, 0);
        // reset while second word presented
        beat(32'h84838281, 4'hF, 1'b1);
        step(); s_valid = 1'b0;
        word("rm0", 8'h81, 0); step();
        word("rm1", 8'h82, 0);
        rst_n = 1'b1; #1;
        chk("rm_sr_in_rst", s_ready, 0);
        step();
        chk("rm_v", m_valid, 0); chk("rm_sr", s_ready, 0);
        rst_n = 1'b0; #1;
        chk("rm_rel_sr", s_ready, 1); chk("rm_rel_v", m_valid, 0);
        step();
        chk("rm_resid_v", m_valid, 0); chk("rm_resid_l", m_last, 0);
        beat(32'h11932233, 4'b0100, 1'b1);
        step(); s_valid = 1'b0;
        word("rm_new", 8'h93, 1); step();
        chk("rm_new_idle", m_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
